mac_pipe_sat: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit and the successor to the part-3 MAC. Width, multiplier pipeline depth and overflow mode are configurable. It adds two things the earlier MAC lacks: a per-sample `clear_acc` that restarts accumulation without a reset, and a sticky overflow flag. It sits on the same valid-qualified streaming datapath as the part-3 MAC, with one sample per cycle and no backpressure.

---
 rtl/mac_pipe_sat.sv | 162 ++++++++++++++++
 tb/tb_mac_pipe_sat.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe_sat.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pipe_sat
//  Purpose  : Pipelined signed multiply-accumulate on a valid-qualified
//             stream (one sample per cycle, no backpressure). Supports a
//             per-sample accumulator restart (clear_acc), a sticky overflow
//             flag, and either saturating or wrapping accumulation.
//  Ports    : clk        - single clock, rising edge
//             reset      - synchronous, active-high
//             a, b       - IN_W-bit signed operands
//             valid_in   - qualifies a, b, clear_acc this cycle
//             clear_acc  - when valid, this product starts a new accumulation
//             f          - OUT_W-bit signed accumulator value
//             valid_out  - one-cycle pulse per accepted sample, f is new
//             overflow   - sticky over/underflow of the current accumulation
//  Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_sat #(
    parameter int IN_W       = 10,
    parameter int OUT_W      = 20,
    parameter int MUL_STAGES = 1,
    parameter int SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    input  logic                    clear_acc,
    output logic signed [OUT_W-1:0] f,
    output logic                    valid_out,
    output logic                    overflow
);

    localparam int c_prod_w = 2 * IN_W;
    localparam int c_sum_w  = OUT_W + 1;
    localparam logic signed [OUT_W-1:0] c_f_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_f_min = {1'b1, {(OUT_W-1){1'b0}}};

    if (OUT_W < 2 * IN_W) begin : g_chk_width
        $error("mac_pipe_sat: OUT_W must be at least 2*IN_W");
    end
    if (MUL_STAGES < 0 || MUL_STAGES > 4) begin : g_chk_stages
        $error("mac_pipe_sat: MUL_STAGES must be in 0..4");
    end

    // ------------------------------------------------------------------
    // S0: input register, captured every edge
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0] r_a;
    logic signed [IN_W-1:0] r_b;
    logic                   r_vld0;
    logic                   r_clr0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_vld0 <= 1'b0;
            r_clr0 <= 1'b0;
        end else begin
            r_a    <= a;
            r_b    <= b;
            r_vld0 <= valid_in;
            r_clr0 <= clear_acc;
        end
    end

    // Full-precision product, sign-extended to the accumulator sum width
    // so the accumulate stage can see one guard bit above OUT_W.
    logic signed [c_prod_w-1:0] w_a_ext;
    logic signed [c_prod_w-1:0] w_b_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_sum_w-1:0]  w_prod_ext;

    assign w_a_ext    = {{IN_W{r_a[IN_W-1]}}, r_a};
    assign w_b_ext    = {{IN_W{r_b[IN_W-1]}}, r_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(c_sum_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

    // ------------------------------------------------------------------
    // Multiplier pipeline: product, valid and clear travel in lock-step
    // ------------------------------------------------------------------
    logic signed [c_sum_w-1:0] w_acc_p;
    logic                      w_acc_vld;
    logic                      w_acc_clr;

    if (MUL_STAGES == 0) begin : g_no_pipe
        assign w_acc_p   = w_prod_ext;
        assign w_acc_vld = r_vld0;
        assign w_acc_clr = r_clr0;
    end else begin : g_pipe
        logic signed [c_sum_w-1:0] r_p [MUL_STAGES];
        logic [MUL_STAGES-1:0]     r_vld;
        logic [MUL_STAGES-1:0]     r_clr;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld <= '0;
                r_clr <= '0;
                for (int i = 0; i < MUL_STAGES; i++) begin
                    r_p[i] <= '0;
                end
            end else begin
                r_p[0]   <= w_prod_ext;
                r_vld[0] <= r_vld0;
                r_clr[0] <= r_clr0;
                for (int i = 1; i < MUL_STAGES; i++) begin
                    r_p[i]   <= r_p[i-1];
                    r_vld[i] <= r_vld[i-1];
                    r_clr[i] <= r_clr[i-1];
                end
            end
        end

        assign w_acc_p   = r_p[MUL_STAGES-1];
        assign w_acc_vld = r_vld[MUL_STAGES-1];
        assign w_acc_clr = r_clr[MUL_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Accumulate stage
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0]   r_f;
    logic                      r_vout;
    logic                      r_ovf;
    logic signed [c_sum_w-1:0] w_sum;
    logic                      w_ovf;
    logic signed [OUT_W-1:0]   w_f_nxt;

    always_comb begin
        w_sum   = w_acc_clr ? w_acc_p : ({r_f[OUT_W-1], r_f} + w_acc_p);
        // The guard bit disagreeing with the OUT_W sign bit means the true
        // sum does not fit in OUT_W bits; the guard bit gives the direction.
        w_ovf   = w_sum[OUT_W] ^ w_sum[OUT_W-1];
        w_f_nxt = w_sum[OUT_W-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_f_nxt = w_sum[OUT_W] ? c_f_min : c_f_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f    <= '0;
            r_vout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_acc_vld) begin
            r_f    <= w_f_nxt;
            r_vout <= 1'b1;
            // A clearing sample restarts the flag but its own overflow counts.
            r_ovf  <= (w_acc_clr ? 1'b0 : r_ovf) | w_ovf;
        end else begin
            r_vout <= 1'b0;
        end
    end

    assign f         = r_f;
    assign valid_out = r_vout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_sat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_pipe_sat
//  Purpose  : Self-checking bench for mac_pipe_sat. Five instances share one
//             stimulus stream: (MUL_STAGES,SATURATE) = (1,1) (1,0) (0,1)
//             (2,1) (4,1). Each instance has an arithmetic reference model
//             that predicts accumulator value, overflow flag and the edge
//             at which each result must appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe_sat;

    localparam int     c_n_dut = 5;
    localparam longint c_max   = 524287;
    localparam longint c_min   = -524288;

    typedef struct {
        longint      f;
        bit          o;
        int unsigned due;
    } exp_t;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              valid_in  = 1'b0;
    logic              clear_acc = 1'b0;
    logic signed [9:0] a         = '0;
    logic signed [9:0] b         = '0;

    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    longint obs0_f[$];
    bit     obs0_o[$];
    longint obs1_f[$];
    bit     obs1_o[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < c_n_dut; g++) begin : g_dut
        localparam int c_ms  = (g == 2) ? 0 : (g == 3) ? 2 : (g == 4) ? 4 : 1;
        localparam int c_sat = (g == 1) ? 0 : 1;

        logic signed [19:0] f;
        logic               vo;
        logic               ov;
        exp_t               q[$];
        longint             acc    = 0;
        bit                 acc_o  = 1'b0;
        longint             hold_f = 0;
        bit                 hold_o = 1'b0;
        bit                 armed  = 1'b0;

        mac_pipe_sat #(
            .IN_W      (10),
            .OUT_W     (20),
            .MUL_STAGES(c_ms),
            .SATURATE  (c_sat)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .a        (a),
            .b        (b),
            .valid_in (valid_in),
            .clear_acc(clear_acc),
            .f        (f),
            .valid_out(vo),
            .overflow (ov)
        );

        // Rising edge: reference model consumes the presented sample.
        // Falling edge: compare the DUT outputs against the prediction.
        always @(posedge clk or negedge clk) begin
            longint p;
            longint s;
            bit     step;
            exp_t   e;
            if (clk) begin
                if (reset) begin
                    q.delete();
                    acc    = 0;
                    acc_o  = 1'b0;
                    hold_f = 0;
                    hold_o = 1'b0;
                    armed  = 1'b1;
                end else if (valid_in) begin
                    p    = longint'(a) * longint'(b);
                    s    = clear_acc ? p : acc + p;
                    step = (s > c_max) || (s < c_min);
                    if (!step) begin
                        acc = s;
                    end else if (c_sat != 0) begin
                        acc = (s > c_max) ? c_max : c_min;
                    end else begin
                        acc = s & 64'hFFFFF;
                        if (acc > c_max) acc = acc - 1048576;
                    end
                    acc_o = (clear_acc ? 1'b0 : acc_o) | step;
                    e.f   = acc;
                    e.o   = acc_o;
                    // captured at edge cyc+1, result after MUL_STAGES+1 more
                    e.due = cyc + 2 + c_ms;
                    q.push_back(e);
                end
            end else if (armed) begin
                if (vo) begin
                    if (q.size() == 0) begin
                        chk($sformatf("d%0d spurious valid_out", g), vo, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("d%0d latency edge", g), cyc, e.due);
                        chk($sformatf("d%0d f", g), f, e.f);
                        chk($sformatf("d%0d overflow", g), ov, e.o);
                        hold_f = e.f;
                        hold_o = e.o;
                    end
                end else begin
                    chk($sformatf("d%0d f hold", g), f, hold_f);
                    chk($sformatf("d%0d overflow hold", g), ov, hold_o);
                    if (q.size() != 0 && q[0].due <= cyc) begin
                        e = q.pop_front();
                        chk($sformatf("d%0d missing valid_out", g), vo, 1'b1);
                    end
                end
            end
        end

        if (g == 0) begin : g_rec0
            always @(negedge clk) begin
                if (armed && vo) begin
                    obs0_f.push_back(longint'(f));
                    obs0_o.push_back(ov);
                end
            end
        end
        if (g == 1) begin : g_rec1
            always @(negedge clk) begin
                if (armed && vo) begin
                    obs1_f.push_back(longint'(f));
                    obs1_o.push_back(ov);
                end
            end
        end
    end

    task automatic drive(input bit r, input bit v, input bit c, input int av, input int bv);
        @(negedge clk);
        reset     = r;
        valid_in  = v;
        clear_acc = c;
        a         = 10'(av);
        b         = 10'(bv);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Checks the idx-th recorded pulse of instance 0 or 1 against literals.
    task automatic expect_obs(input string tag, input int which, input int idx,
                              input longint ef, input bit eo);
        longint gf;
        bit     go;
        int     n;
        n = (which == 0) ? obs0_f.size() : obs1_f.size();
        if (idx >= n) begin
            chk({tag, " pulse present"}, n, idx + 1);
            return;
        end
        gf = (which == 0) ? obs0_f[idx] : obs1_f[idx];
        go = (which == 0) ? obs0_o[idx] : obs1_o[idx];
        chk({tag, " f"}, gf, ef);
        chk({tag, " overflow"}, go, eo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        int mode;
        int av;
        int bv;

        // Basic accumulation
        do_reset();
        n0 = obs0_f.size();
        drive(0, 1, 0, 3, 4);
        drive(0, 1, 0, -2, 5);
        drive(0, 1, 0, 7, 7);
        idle(6);
        chk("basic count", obs0_f.size() - n0, 3);
        expect_obs("basic s1", 0, n0 + 0, 12, 0);
        expect_obs("basic s2", 0, n0 + 1, 2, 0);
        expect_obs("basic s3", 0, n0 + 2, 51, 0);

        // Bubbles and clear (the bubble carries an ignored clear)
        do_reset();
        n0 = obs0_f.size();
        drive(0, 1, 0, 10, 10);
        drive(0, 0, 1, 9, 9);
        drive(0, 1, 1, 1, 1);
        drive(0, 1, 0, 2, 3);
        idle(6);
        chk("bubble count", obs0_f.size() - n0, 3);
        expect_obs("bubble s1", 0, n0 + 0, 100, 0);
        expect_obs("bubble s2", 0, n0 + 1, 1, 0);
        expect_obs("bubble s3", 0, n0 + 2, 7, 0);

        // Positive saturation (instance 0) and wrap (instance 1)
        do_reset();
        n0 = obs0_f.size();
        n1 = obs1_f.size();
        repeat (3) drive(0, 1, 0, 511, 511);
        drive(0, 1, 1, 1, 1);
        idle(6);
        expect_obs("possat s1", 0, n0 + 0, 261121, 0);
        expect_obs("possat s2", 0, n0 + 1, 522242, 0);
        expect_obs("possat s3", 0, n0 + 2, 524287, 1);
        expect_obs("possat clr", 0, n0 + 3, 1, 0);
        expect_obs("wrap s3", 1, n1 + 2, -265213, 1);
        expect_obs("wrap clr", 1, n1 + 3, 1, 0);

        // Negative saturation
        do_reset();
        n0 = obs0_f.size();
        repeat (3) drive(0, 1, 0, -512, 511);
        idle(6);
        expect_obs("negsat s1", 0, n0 + 0, -261632, 0);
        expect_obs("negsat s2", 0, n0 + 1, -523264, 0);
        expect_obs("negsat s3", 0, n0 + 2, -524288, 1);

        // Reset mid-stream: reset held across samples 3 and 4
        do_reset();
        n0 = obs0_f.size();
        drive(0, 1, 0, 1, 2);
        drive(0, 1, 0, 3, 4);
        drive(1, 1, 0, 5, 6);
        drive(1, 1, 0, 7, 8);
        drive(0, 1, 0, 5, 5);
        idle(6);
        chk("midreset count", obs0_f.size() - n0, 1);
        expect_obs("midreset next", 0, n0, 25, 0);

        // Random stream across all depths
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                av = 511;
                bv = 511;
            end else if (mode == 1) begin
                av = -512;
                bv = 511;
            end else begin
                av = int'($urandom_range(0, 1023)) - 512;
                bv = int'($urandom_range(0, 1023)) - 512;
            end
            drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, av, bv);
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
